// File: rtl/dct8_pipe.sv
// dct8_pipe: fully pipelined 8-point 1-D forward DCT (Q7 coefficients).
//
// Purpose: accepts one vector x0..x7 per cycle and returns y0..y7 in natural
// order, orthonormal-scaled, after 4 register stages (S1 butterfly, S2 even
// sums + odd products, S3 coefficient sums, S4 round/shift/clamp). A bypass
// beat (i_mode=1) returns the sign-extended samples instead.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       input handshake (vector + i_mode + i_last)
//   i_data0..i_data7        signed IN_W samples
//   o_valid / i_ready       output handshake
//   o_last, o_sat           end-of-block tag, "some coefficient was clamped"
//   o_data0..o_data7        signed OUT_W coefficients
//
// Handshake: a beat moves across an interface on a rising edge where
// valid & ready are both high. The whole pipeline advances as one unit
// (adv = !o_valid | i_ready); o_ready is adv, so while the output is held the
// input is refused and every stage, including bubbles, freezes in place.
`timescale 1ns/1ps
module dct8_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = IN_W + 3,
    parameter bit ROUND = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_mode,
    input  logic                    i_last,
    input  logic signed [IN_W-1:0]  i_data0,
    input  logic signed [IN_W-1:0]  i_data1,
    input  logic signed [IN_W-1:0]  i_data2,
    input  logic signed [IN_W-1:0]  i_data3,
    input  logic signed [IN_W-1:0]  i_data4,
    input  logic signed [IN_W-1:0]  i_data5,
    input  logic signed [IN_W-1:0]  i_data6,
    input  logic signed [IN_W-1:0]  i_data7,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_sat,
    output logic signed [OUT_W-1:0] o_data0,
    output logic signed [OUT_W-1:0] o_data1,
    output logic signed [OUT_W-1:0] o_data2,
    output logic signed [OUT_W-1:0] o_data3,
    output logic signed [OUT_W-1:0] o_data4,
    output logic signed [OUT_W-1:0] o_data5,
    output logic signed [OUT_W-1:0] o_data6,
    output logic signed [OUT_W-1:0] o_data7
);

    localparam int AW = IN_W + 1;   // butterfly outputs
    localparam int EW = IN_W + 2;   // even-part sums
    localparam int PW = IN_W + 12;  // lossless product/sum width

    localparam logic signed [PW-1:0] C1 = PW'(126);
    localparam logic signed [PW-1:0] C2 = PW'(118);
    localparam logic signed [PW-1:0] C3 = PW'(106);
    localparam logic signed [PW-1:0] C4 = PW'(91);
    localparam logic signed [PW-1:0] C5 = PW'(71);
    localparam logic signed [PW-1:0] C6 = PW'(49);
    localparam logic signed [PW-1:0] C7 = PW'(25);
    localparam logic signed [PW-1:0] RND  = ROUND ? PW'(128) : '0;
    localparam logic signed [PW-1:0] MAXV = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Odd coefficients in the order c1, c3, c5, c7.
    function automatic logic signed [PW-1:0] odd_c(input int i);
        case (i)
            0:       return C1;
            1:       return C3;
            2:       return C5;
            default: return C7;
        endcase
    endfunction

    logic adv;
    logic signed [IN_W-1:0] x_in [8];

    // S1
    logic                   v1_q, v1_d, m1_q, m1_d, l1_q, l1_d;
    logic signed [IN_W-1:0] x1_q [8], x1_d [8];
    logic signed [AW-1:0]   a_q [8], a_d [8];
    // S2: pr[j*4+i] = odd_c(i) * a(7-j)
    logic                   v2_q, v2_d, m2_q, m2_d, l2_q, l2_d;
    logic signed [IN_W-1:0] x2_q [8], x2_d [8];
    logic signed [EW-1:0]   e_q [4], e_d [4];
    logic signed [PW-1:0]   pr_q [16], pr_d [16];
    // S3
    logic                   v3_q, v3_d, m3_q, m3_d, l3_q, l3_d;
    logic signed [IN_W-1:0] x3_q [8], x3_d [8];
    logic signed [PW-1:0]   p_q [8], p_d [8];
    // S4 (output registers)
    logic                   ov_q, ov_d, ol_q, ol_d, os_q, os_d;
    logic signed [OUT_W-1:0] y_q [8], y_d [8];
    logic signed [PW-1:0]   t;
    logic                   sat;

    always_comb begin
        x_in[0] = i_data0; x_in[1] = i_data1; x_in[2] = i_data2; x_in[3] = i_data3;
        x_in[4] = i_data4; x_in[5] = i_data5; x_in[6] = i_data6; x_in[7] = i_data7;
        adv = !ov_q || i_ready;

        v1_d = v1_q; m1_d = m1_q; l1_d = l1_q; x1_d = x1_q; a_d = a_q;
        v2_d = v2_q; m2_d = m2_q; l2_d = l2_q; x2_d = x2_q; e_d = e_q; pr_d = pr_q;
        v3_d = v3_q; m3_d = m3_q; l3_d = l3_q; x3_d = x3_q; p_d = p_q;
        ov_d = ov_q; ol_d = ol_q; os_d = os_q; y_d = y_q;
        t    = '0;
        sat  = 1'b0;

        if (adv) begin
            // S1: butterfly; i_valid=0 loads a bubble
            v1_d = i_valid; m1_d = i_mode; l1_d = i_last; x1_d = x_in;
            for (int k = 0; k < 4; k++) begin
                a_d[k]     = AW'(x_in[k]) + AW'(x_in[7-k]);
                a_d[7-k]   = AW'(x_in[k]) - AW'(x_in[7-k]);
            end

            // S2: even sums and the 16 odd-part products
            v2_d = v1_q; m2_d = m1_q; l2_d = l1_q; x2_d = x1_q;
            e_d[0] = EW'(a_q[0]) + EW'(a_q[3]);
            e_d[1] = EW'(a_q[1]) + EW'(a_q[2]);
            e_d[2] = EW'(a_q[1]) - EW'(a_q[2]);
            e_d[3] = EW'(a_q[0]) - EW'(a_q[3]);
            for (int j = 0; j < 4; j++) begin
                for (int i = 0; i < 4; i++) begin
                    pr_d[j*4+i] = PW'(a_q[7-j]) * odd_c(i);
                end
            end

            // S3: per-coefficient sums (odd terms index pr as c{1,3,5,7} x a{7,6,5,4})
            v3_d = v2_q; m3_d = m2_q; l3_d = l2_q; x3_d = x2_q;
            p_d[0] = C4 * (PW'(e_q[0]) + PW'(e_q[1]));
            p_d[4] = C4 * (PW'(e_q[0]) - PW'(e_q[1]));
            p_d[2] = C2 * PW'(e_q[3]) + C6 * PW'(e_q[2]);
            p_d[6] = C6 * PW'(e_q[3]) - C2 * PW'(e_q[2]);
            p_d[1] = pr_q[0] + pr_q[5] + pr_q[10] + pr_q[15];
            p_d[3] = pr_q[1] - pr_q[7] - pr_q[8]  - pr_q[14];
            p_d[5] = pr_q[2] - pr_q[4] + pr_q[11] + pr_q[13];
            p_d[7] = pr_q[3] - pr_q[6] + pr_q[9]  - pr_q[12];

            // S4: round, arithmetic shift, clamp; bypass discards the DCT value
            ov_d = v3_q; ol_d = l3_q;
            for (int k = 0; k < 8; k++) begin
                if (m3_q) begin
                    y_d[k] = OUT_W'(x3_q[k]);
                end else begin
                    t = (p_q[k] + RND) >>> 8;
                    if (t > MAXV) begin
                        y_d[k] = MAXV[OUT_W-1:0];
                        sat    = 1'b1;
                    end else if (t < MINV) begin
                        y_d[k] = MINV[OUT_W-1:0];
                        sat    = 1'b1;
                    end else begin
                        y_d[k] = t[OUT_W-1:0];
                    end
                end
            end
            os_d = sat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0; m1_q <= 1'b0; l1_q <= 1'b0;
            v2_q <= 1'b0; m2_q <= 1'b0; l2_q <= 1'b0;
            v3_q <= 1'b0; m3_q <= 1'b0; l3_q <= 1'b0;
            ov_q <= 1'b0; ol_q <= 1'b0; os_q <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                x1_q[k] <= '0; x2_q[k] <= '0; x3_q[k] <= '0;
                a_q[k]  <= '0; p_q[k]  <= '0; y_q[k]  <= '0;
            end
            for (int k = 0; k < 4; k++)  e_q[k]  <= '0;
            for (int k = 0; k < 16; k++) pr_q[k] <= '0;
        end else begin
            v1_q <= v1_d; m1_q <= m1_d; l1_q <= l1_d; x1_q <= x1_d; a_q <= a_d;
            v2_q <= v2_d; m2_q <= m2_d; l2_q <= l2_d; x2_q <= x2_d; e_q <= e_d; pr_q <= pr_d;
            v3_q <= v3_d; m3_q <= m3_d; l3_q <= l3_d; x3_q <= x3_d; p_q <= p_d;
            ov_q <= ov_d; ol_q <= ol_d; os_q <= os_d; y_q <= y_d;
        end
    end

    assign o_ready = adv;
    assign o_valid = ov_q;
    assign o_last  = ol_q;
    assign o_sat   = os_q;
    assign o_data0 = y_q[0];
    assign o_data1 = y_q[1];
    assign o_data2 = y_q[2];
    assign o_data3 = y_q[3];
    assign o_data4 = y_q[4];
    assign o_data5 = y_q[5];
    assign o_data6 = y_q[6];
    assign o_data7 = y_q[7];

endmodule

// File: tb/tb_dct8_pipe.sv
// tb_dct8_pipe: self-checking bench for dct8_pipe.
// Three instances share the stimulus: default parameters, a narrow OUT_W=9
// instance for clamping, and a ROUND=0 instance. The reference model computes
// each coefficient as a plain dot product against the cosine table.
`timescale 1ns/1ps
module tb_dct8_pipe;
    localparam int IN_W  = 8;
    localparam int OUT_W = 11;
    localparam int SAT_W = 9;
    localparam int W     = 2 + 8*OUT_W;

    typedef int vec_t [8];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_mode = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic signed [IN_W-1:0] din [8];

    logic o_ready, o_valid, o_last, o_sat;
    logic signed [OUT_W-1:0] dout [8];
    logic s_ready, s_valid, s_last, s_sat;
    logic signed [SAT_W-1:0] sdout [8];
    logic f_ready, f_valid, f_last, f_sat;
    logic signed [OUT_W-1:0] fdout [8];

    logic [W-1:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dct8_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .ROUND(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(o_ready),
        .i_mode(in_mode), .i_last(in_last),
        .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]), .i_data3(din[3]),
        .i_data4(din[4]), .i_data5(din[5]), .i_data6(din[6]), .i_data7(din[7]),
        .o_valid(o_valid), .i_ready(out_ready), .o_last(o_last), .o_sat(o_sat),
        .o_data0(dout[0]), .o_data1(dout[1]), .o_data2(dout[2]), .o_data3(dout[3]),
        .o_data4(dout[4]), .o_data5(dout[5]), .o_data6(dout[6]), .o_data7(dout[7]));

    dct8_pipe #(.IN_W(IN_W), .OUT_W(SAT_W), .ROUND(1'b1)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(s_ready),
        .i_mode(in_mode), .i_last(in_last),
        .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]), .i_data3(din[3]),
        .i_data4(din[4]), .i_data5(din[5]), .i_data6(din[6]), .i_data7(din[7]),
        .o_valid(s_valid), .i_ready(out_ready), .o_last(s_last), .o_sat(s_sat),
        .o_data0(sdout[0]), .o_data1(sdout[1]), .o_data2(sdout[2]), .o_data3(sdout[3]),
        .o_data4(sdout[4]), .o_data5(sdout[5]), .o_data6(sdout[6]), .o_data7(sdout[7]));

    dct8_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .ROUND(1'b0)) u_flr (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(f_ready),
        .i_mode(in_mode), .i_last(in_last),
        .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]), .i_data3(din[3]),
        .i_data4(din[4]), .i_data5(din[5]), .i_data6(din[6]), .i_data7(din[7]),
        .o_valid(f_valid), .i_ready(out_ready), .o_last(f_last), .o_sat(f_sat),
        .o_data0(fdout[0]), .o_data1(fdout[1]), .o_data2(fdout[2]), .o_data3(fdout[3]),
        .o_data4(fdout[4]), .o_data5(fdout[5]), .o_data6(fdout[6]), .o_data7(fdout[7]));

    // ---------------- checkers ----------------
    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Q7 value of cos(m*pi/16) built from c1..c7 using cosine symmetry.
    function automatic int cq(input int m_in);
        int m;
        int tab [9];
        tab = '{128, 126, 118, 106, 91, 71, 49, 25, 0};
        m = m_in % 32;
        if (m > 16) m = 32 - m;
        if (m <= 8) return tab[m];
        return -tab[16 - m];
    endfunction

    task automatic ref_model(input vec_t x, input bit mode, input int out_w, input bit rnd,
                             output vec_t y, output bit sat);
        int p, v, hi, lo;
        sat = 1'b0;
        hi = (1 << (out_w - 1)) - 1;
        lo = -(1 << (out_w - 1));
        for (int k = 0; k < 8; k++) begin
            if (mode) begin
                y[k] = x[k];
            end else begin
                p = 0;
                for (int n = 0; n < 8; n++)
                    p += ((k == 0) ? 91 : cq((2*n + 1) * k)) * x[n];
                v = (p + (rnd ? 128 : 0)) >>> 8;
                if (v > hi) begin v = hi; sat = 1'b1; end
                if (v < lo) begin v = lo; sat = 1'b1; end
                y[k] = v;
            end
        end
    endtask

    function automatic logic [W-1:0] pack_exp(input vec_t y, input bit sat, input bit last);
        logic [W-1:0] r;
        r = '0;
        r[W-1] = last;
        r[W-2] = sat;
        for (int k = 0; k < 8; k++) r[k*OUT_W +: OUT_W] = OUT_W'(y[k]);
        return r;
    endfunction

    function automatic logic [W-1:0] pack_obs();
        logic [W-1:0] r;
        r = '0;
        r[W-1] = o_last;
        r[W-2] = o_sat;
        for (int k = 0; k < 8; k++) r[k*OUT_W +: OUT_W] = dout[k];
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    task automatic monitor();
        logic [W-1:0] obs, prev;
        bit prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            obs = pack_obs();
            chk("o_ready_rule", o_ready, (!o_valid || out_ready));
            if (prev_stall) chk_vec("stall_hold", obs, prev);
            if (o_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        failures++;
                        $error("FAIL unexpected_beat observed=%h expected=none", obs);
                    end
                end else begin
                    chk_vec("beat", obs, exp_q.pop_front());
                end
            end
            prev_stall = o_valid && !out_ready;
            prev = obs;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input vec_t x, input bit mode, input bit last);
        vec_t y;
        bit sat, acc;
        for (int k = 0; k < 8; k++) din[k] = x[k][IN_W-1:0];
        in_mode = mode;
        in_last = last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        chk("accept", acc, 1);
        in_valid = 1'b0;
        ref_model(x, mode, OUT_W, 1'b1, y, sat);
        exp_q.push_back(pack_exp(y, sat, last));
    endtask

    // Sends one beat and returns how many edges (accept edge = 1) until o_valid.
    task automatic run_single(input vec_t x, input bit mode, input bit last, output int lat);
        send(x, mode, last);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (o_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t r;
        for (int k = 0; k < 8; k++) r[k] = int'($urandom_range(0, 255)) - 128;
        return r;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        vec_t x, ey;
        int lat;

        for (int k = 0; k < 8; k++) din[k] = '0;
        fork
            monitor();
        join_none

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_o_sat", o_sat, 0);
        chk("rst_o_data0", dout[0], 0);
        chk("rst_o_data7", dout[7], 0);
        chk("rst_o_ready", o_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_o_ready", o_ready, 1);

        // impulse, ROUND=1 and ROUND=0
        x = '{64, 0, 0, 0, 0, 0, 0, 0};
        run_single(x, 1'b0, 1'b1, lat);
        chk("impulse_latency", lat, 4);
        ey = '{23, 32, 30, 27, 23, 18, 12, 6};
        for (int k = 0; k < 8; k++) chk($sformatf("impulse_y%0d", k), dout[k], ey[k]);
        chk("impulse_sat", o_sat, 0);
        chk("impulse_last", o_last, 1);
        ey = '{22, 31, 29, 26, 22, 17, 12, 6};
        for (int k = 0; k < 8; k++) chk($sformatf("floor_impulse_y%0d", k), fdout[k], ey[k]);
        @(posedge clk);
        #1;

        // DC +100
        x = '{100, 100, 100, 100, 100, 100, 100, 100};
        run_single(x, 1'b0, 1'b0, lat);
        chk("dc100_latency", lat, 4);
        chk("dc100_y0", dout[0], 284);
        for (int k = 1; k < 8; k++) chk($sformatf("dc100_y%0d", k), dout[k], 0);
        @(posedge clk);
        #1;

        // DC -128
        x = '{-128, -128, -128, -128, -128, -128, -128, -128};
        run_single(x, 1'b0, 1'b0, lat);
        chk("dcm128_y0", dout[0], -364);
        for (int k = 1; k < 8; k++) chk($sformatf("dcm128_y%0d", k), dout[k], 0);
        @(posedge clk);
        #1;

        // saturation on the OUT_W=9 instance, then the same beat in bypass
        x = '{127, 127, 127, 127, 127, 127, 127, 127};
        run_single(x, 1'b0, 1'b0, lat);
        chk("sat9_y0", sdout[0], 255);
        chk("sat9_flag", s_sat, 1);
        chk("sat9_wide_flag", o_sat, 0);
        @(posedge clk);
        #1;
        run_single(x, 1'b1, 1'b1, lat);
        for (int k = 0; k < 8; k++) chk($sformatf("byp9_y%0d", k), sdout[k], 127);
        chk("byp9_flag", s_sat, 0);
        @(posedge clk);
        #1;

        // random stream with alternating mode, mid-stream stall
        fork
            begin
                for (int i = 0; i < 16; i++) send(rand_vec(), (i % 2) == 1, (i % 8) == 7);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        chk("stream_drain", exp_q.size(), 0);
        #1;

        // reset pulse with three beats in flight
        for (int i = 0; i < 3; i++) send(rand_vec(), 1'b0, i == 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_last", o_last, 0);
        chk("midrst_o_sat", o_sat, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("midrst_y%0d", k), dout[k], 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("flushed_o_valid", o_valid, 0);
        run_single(rand_vec(), 1'b0, 1'b1, lat);
        chk("post_flush_latency", lat, 4);
        repeat (4) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
